// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit path: default widths and the
// lrclk channel encoding.
package i2s_pkg;

  localparam int I2S_DATA_BIT_WIDTH = 24;
  localparam int SLOT_BIT_WIDTH     = 32;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample-source handshake plus serial link of the I2S transmitter.
// master = sample source / link observer, slave = the transmitter itself.
interface i2s_transmitter_if
  import i2s_pkg::*;
#(
  parameter int W = I2S_DATA_BIT_WIDTH
);

  logic [W-1:0] s_left;
  logic [W-1:0] s_right;
  logic         s_valid;
  logic         s_ready;
  logic         lrclk;
  logic         sdata;
  logic         tx_underrun;

  modport master (
    output s_left, s_right, s_valid,
    input  s_ready, lrclk, sdata, tx_underrun
  );

  modport slave (
    input  s_left, s_right, s_valid,
    output s_ready, lrclk, sdata, tx_underrun
  );

endinterface

// File: rtl/i2s_slot_timer.sv
// Slot position counter and lrclk generator. slot_start / left_start are
// high in the cycle whose closing edge begins a new slot / a new left slot.
module i2s_slot_timer #(
  parameter int SLOT_BIT_WIDTH = i2s_pkg::SLOT_BIT_WIDTH
) (
  input  logic                              bclk,
  input  logic                              rst,
  output logic [$clog2(SLOT_BIT_WIDTH)-1:0] k,
  output logic                              lrclk,
  output logic                              slot_start,
  output logic                              left_start
);
  import i2s_pkg::*;

  localparam int KW = $clog2(SLOT_BIT_WIDTH);

  assign slot_start = (k == KW'(SLOT_BIT_WIDTH - 1));
  assign left_start = slot_start && (lrclk == LR_RIGHT);

  // Reset parks the timer on the last cycle of a right slot, so the first
  // edge after release opens a left slot.
  always_ff @(posedge bclk) begin
    if (!rst) begin
      k     <= KW'(SLOT_BIT_WIDTH - 1);
      lrclk <= LR_RIGHT;
    end else if (slot_start) begin
      k     <= '0;
      lrclk <= ~lrclk;
    end else begin
      k     <= k + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: one-entry holding buffer, frame register and MSB-first
// shifter with a one-bit delay. Define I2S_TX_UNDERRUN_COUNT_EN for underrun_count.
module i2s_transmitter #(
  parameter int I2S_DATA_BIT_WIDTH = i2s_pkg::I2S_DATA_BIT_WIDTH,
  parameter int SLOT_BIT_WIDTH     = i2s_pkg::SLOT_BIT_WIDTH
) (
  input  logic                bclk,
  input  logic                rst,
  i2s_transmitter_if.slave    bus
`ifdef I2S_TX_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]         underrun_count
`endif
);
  import i2s_pkg::*;

  localparam int W  = I2S_DATA_BIT_WIDTH;
  localparam int S  = SLOT_BIT_WIDTH;
  localparam int KW = $clog2(S);

  logic [KW-1:0] k;
  logic          lrclk;
  logic          slot_start;
  logic          left_start;

  logic          hold_full;
  logic [W-1:0]  hold_left;
  logic [W-1:0]  hold_right;
  logic [W-1:0]  frame_left;
  logic [W-1:0]  frame_right;
  logic [W-1:0]  word;
  logic [W-1:0]  shreg;
  logic          sdata_q;
  logic          underrun_q;
  logic          accept;
  logic          underrun_now;

  i2s_slot_timer #(
    .SLOT_BIT_WIDTH (S)
  ) u_slot_timer (
    .bclk       (bclk),
    .rst        (rst),
    .k          (k),
    .lrclk      (lrclk),
    .slot_start (slot_start),
    .left_start (left_start)
  );

  // Ready is gated by the raw reset input so the source sees no room while
  // the block is held in reset, regardless of the stale flag value.
  assign bus.s_ready   = rst && !hold_full;
  assign accept        = bus.s_valid && bus.s_ready;
  assign underrun_now  = left_start && !hold_full;

  assign bus.lrclk       = lrclk;
  assign bus.sdata       = sdata_q;
  assign bus.tx_underrun = underrun_q;

  // NOTE: the holding words are data only; hold_full alone says whether they
  // mean anything, so they need no reset and reset discards them implicitly.
  always_ff @(posedge bclk) begin
    if (accept) begin
      hold_left  <= bus.s_left;
      hold_right <= bus.s_right;
    end
  end

  // An accept on a frame-load edge can only happen with the buffer empty, so
  // it counts as an underrun and its frame waits in hold for the next frame.
  always_ff @(posedge bclk) begin
    if (!rst) begin
      hold_full   <= 1'b0;
      frame_left  <= '0;
      frame_right <= '0;
      underrun_q  <= 1'b0;
    end else begin
      underrun_q <= underrun_now;
      if (left_start) begin
        if (hold_full) begin
          frame_left  <= hold_left;
          frame_right <= hold_right;
        end else begin
          frame_left  <= '0;
          frame_right <= '0;
        end
      end
      if (accept) begin
        hold_full <= 1'b1;
      end else if (left_start) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign word = (lrclk == LR_LEFT) ? frame_left : frame_right;

  // Slot cycle 0 is the idle I2S delay bit; the MSB is registered on the
  // edge leaving cycle 0, the LSB on the edge leaving cycle W-1.
  always_ff @(posedge bclk) begin
    if (!rst) begin
      sdata_q <= 1'b0;
      shreg   <= '0;
    end else if (slot_start) begin
      sdata_q <= 1'b0;
    end else if (k == '0) begin
      sdata_q <= word[W-1];
      shreg   <= {word[W-2:0], 1'b0};
    end else if (k < KW'(W)) begin
      sdata_q <= shreg[W-1];
      shreg   <= {shreg[W-2:0], 1'b0};
    end else begin
      sdata_q <= 1'b0;
    end
  end

`ifdef I2S_TX_UNDERRUN_COUNT_EN
  always_ff @(posedge bclk) begin
    if (!rst) begin
      underrun_count <= '0;
    end else if (underrun_now && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
Serialises stereo PCM frames onto an I2S link (lrclk, sdata), clocked by bclk. It is the upstream partner of the I2S receiver stage: its lrclk/sdata outputs connect directly to the receiver's inputs on the same bclk. The sample source writes frames through a one-entry valid/ready holding buffer. If no frame is available at a frame boundary, the block sends silence.

Parameters:
I2S_DATA_BIT_WIDTH, 24, sample width in bits per channel (W).
SLOT_BIT_WIDTH, 32, bclk cycles per lrclk half-period (S); must be >= W+1.

Ports:
bclk  input  1  bit clock; all logic on posedge.
rst  input  1  synchronous, active-low reset.
s_left  input  W  left sample, two's complement.
s_right  input  W  right sample.
s_valid  input  1  source has a frame on s_left/s_right.
s_ready  output  1  holding buffer empty; frame accepted when s_valid && s_ready at posedge.
lrclk  output  1  word select; 0 = left slot, 1 = right slot.
sdata  output  1  serial data, MSB first.
tx_underrun  output  1  one-cycle pulse when a frame boundary finds the holding buffer empty.
underrun_count  output  16  only with the optional feature.

Behaviour:
- State:
  - slot counter k (0..S-1);
  - lrclk register;
  - frame register (left and right words);
  - holding buffer plus hold_full flag;
  - W-bit output shift register.
- Reset (rst==0 at posedge):
  - lrclk=1, k=S-1, sdata=0, hold_full=0, tx_underrun=0, frame register=0, underrun_count=0.
  - s_ready=0 while rst==0.
- After reset release, s_ready = !hold_full (combinational from the registered flag).
- Slot timing:
  - k increments every posedge.
  - When k==S-1, k wraps to 0 and lrclk toggles on that same edge.
  - The first edge after reset release therefore starts a left slot with lrclk=0.
- Frame load: occurs on the edge where lrclk goes 1->0 (the start of a left slot).
  - If hold_full: the frame register takes the holding buffer and hold_full clears.
  - Else: the frame register is loaded with zeros and tx_underrun pulses for one cycle.
- Accept: s_valid && s_ready at an edge writes the holding buffer and sets hold_full.
  - If an accept lands on the same edge as a frame load with the buffer empty, that is still an underrun.
  - The accepted frame stays in hold and is sent in the next frame.
- Shift register load:
  - Loads the left word at k==0 of the left slot.
  - Loads the right word at k==0 of the right slot.
- Serial output (one-bit I2S delay):
  - Registered sdata at slot cycle k=1..W carries bit W-k of the current word.
  - At k=0 and k=W+1..S-1, sdata=0.
- Timing relationship:
  - lrclk and sdata are registered on posedge bclk.
  - A receiver sampling on posedge bclk sees the lrclk change one edge later, then the MSB on the following edge.
- Latency: a frame accepted while the buffer is empty appears at the next left-slot start. Its MSB is on sdata 1 cycle after lrclk falls.
- Back-pressure: at most one frame is buffered. s_ready stays low from the accept until the next frame load.
- Reset mid-frame: the current frame is aborted and the hold contents are discarded. Timing restarts from the reset state. There is no partial-word completion.

Optional Feature:
I2S_TX_UNDERRUN_COUNT_EN:
- Defined: adds the underrun_count output, a 16-bit counter that increments on each tx_underrun, saturates at 16'hFFFF, and clears only on reset.
- Undefined: the port and counter are absent; tx_underrun is still present.

Decomposition:
- Shared package i2s_pkg holds:
  - default width constants (I2S_DATA_BIT_WIDTH=24, SLOT_BIT_WIDTH=32);
  - channel encoding constants (LR_LEFT=0, LR_RIGHT=1).
- One natural sub-module: i2s_slot_timer, containing the k counter and lrclk register.
  - Outputs: slot_start and left_start strobes.
  - The top level holds the buffer, frame register and shifter.

Test Plan:
1. Release reset with s_valid=0 for 2 frames. Required: lrclk toggles every 32 cycles, sdata stays 0, tx_underrun pulses once per left-slot start, s_ready=1.
2. Write left=24'hA5A5A5, right=24'h5A5A5A before the first frame boundary. Required: on sdata after lrclk falls, 1 idle bit, then A5A5A5 MSB-first, then zeros until lrclk rises; the right slot likewise carries 5A5A5A.
3. Loopback into the I2S receiver (W=24). Stream 8 frames of incrementing samples 1..16. Required: the receiver captures every value in order with the correct channel bit and no underrun.
4. Hold s_valid=1 continuously. Required: s_ready deasserts after each accept and reasserts on the edge after each left-slot start; exactly one accept per 64 cycles.
5. Accept a frame on exactly the edge of a frame load. Required: tx_underrun=1 and zeros are sent that frame; the accepted frame is sent in the next frame.
6. Assert rst mid right slot. Required: on the next edge lrclk=1, sdata=0, s_ready=0; after release, a fresh left slot starts and the old hold contents are never transmitted. With I2S_TX_UNDERRUN_COUNT_EN, the counter reads 0 after reset.
